uart_word_rx: RTL
=================

# uart_word_rx

Standalone UART receiver that deserializes 8N1 byte frames from a serial line and assembles them into `DATA_BITS`-wide words, LSB byte first. It is the receive end for the existing 32-bit UART transmit path. It sits between an external `Rx` pin (or an on-chip transmitter's `Tx`) and word-level consumer logic. It includes input synchronization, mid-bit sampling, glitch rejection and framing-error detection.

## Interface
- `DATA_BITS`, default 32: output word width. Must be a multiple of 8; bytes per word `NB = DATA_BITS/8`.
- `CLKS_PER_BIT`, default 16: `clk` cycles per serial bit. Must be even and ≥ 4.
- `clk` input, 1 bit: single clock domain; all logic on the rising edge.
- `reset` input, 1 bit: asynchronous, active-low reset.
- `Rx` input, 1 bit: serial line, asynchronous to `clk`; idles high.
- `RxData` output, `DATA_BITS` bits: last completed word; holds its value until the next word completes.
- `RxValid` output, 1 bit: one-cycle pulse when `RxData` is updated.
- `RxFrameErr` output, 1 bit: one-cycle pulse on a bad stop bit.
- `RxBusy` output, 1 bit: high while a frame is in progress (any state other than IDLE).

## Operation
- **Input synchronizer:** `Rx` passes through a 2-flop synchronizer. Both flops reset to 1. All decisions use the synchronized value `rx_s`.
- **Reset values:**
  - `RxData` = 0, `RxValid` = 0, `RxFrameErr` = 0, `RxBusy` = 0.
  - State = IDLE, byte index = 0, bit/clock counters = 0, partial word = 0.
- **States:**
  - **IDLE:** when `rx_s` = 0, go to START and clear the clock counter.
  - **START:** count `CLKS_PER_BIT/2` cycles, then sample `rx_s`.
    - 0: go to DATA; bit counter = 0; clock counter = 0.
    - 1: glitch; return to IDLE. No flags raised; partial word untouched.
  - **DATA:** sample `rx_s` every `CLKS_PER_BIT` cycles, 8 bits, LSB first, into the byte shift register. After bit 7, go to STOP.
  - **STOP:** sample once after `CLKS_PER_BIT` cycles.
    - 1: write the byte into partial word bits `[8*idx+7 : 8*idx]`.
      - If `idx == NB-1`: on the next edge load `RxData` with the full word, pulse `RxValid`, and set `idx` = 0.
      - Otherwise: `idx` += 1.
      - Return to IDLE in both cases.
    - 0: pulse `RxFrameErr`, discard the byte, set `idx` = 0 (the partial word is abandoned), then go to BREAK.
  - **BREAK:** wait until `rx_s` = 1, then go to IDLE. A line held low never produces further frames.
- `RxValid` and `RxFrameErr` are never high in the same cycle.
- Partial words persist indefinitely between bytes. There is no inter-byte timeout; only reset or a framing error clears them.
- No back-pressure: a new `RxValid` overwrites `RxData` regardless of the consumer.

## Timing
- Let t0 be the first `clk` edge at which `Rx` = 0 is captured by flop 1. Then:
  - `rx_s` = 0 at t0+1.
  - START sample at t0+1+`CLKS_PER_BIT/2`.
  - Data bit i sampled at (start sample) + (i+1)·`CLKS_PER_BIT`.
  - Stop bit sampled at (start sample) + 9·`CLKS_PER_BIT`.
  - `RxValid` / `RxFrameErr` high in the cycle immediately after the stop sample, for exactly 1 cycle.
- The state returns to IDLE in the same cycle the pulse is high. A start edge arriving directly after the stop-bit midpoint (back-to-back frames) must be accepted with no lost cycles.
- `RxBusy` rises the cycle after IDLE→START and falls the cycle the state re-enters IDLE.
- Asynchronous reset mid-frame:
  - Outputs go to their reset values immediately.
  - After release, the block waits in IDLE for `rx_s` = 0. The synchronizer's reset value of 1 prevents a false start.
- Data sampled at the bit midpoint tolerates about ±(`CLKS_PER_BIT/2`−2) cycles of cumulative drift per frame.

## Test plan
All scenarios use `CLKS_PER_BIT` = 16 and `DATA_BITS` = 32.
1. **Basic word:** send frames 0xEF, 0xBE, 0xAD, 0xDE with idle gaps → exactly one `RxValid` pulse, `RxData` = 0xDEADBEEF, `RxFrameErr` never high.
2. **Glitch rejection:** drive `Rx` low for 5 cycles, then high → `RxBusy` pulses, returns to 0; no `RxValid`/`RxFrameErr`. The following word 0x01020304 is received intact.
3. **Framing error:** send 0x11, 0x22, then 0x33 with stop bit = 0 → one `RxFrameErr` pulse, no `RxValid`. Then 0x44, 0x33, 0x22, 0x11 → `RxData` = 0x11223344.
4. **Reset mid-word:** send 2 bytes, assert `reset` low for 3 cycles mid-third-frame, release, send 0x44, 0x33, 0x22, 0x11 → single `RxValid`, `RxData` = 0x11223344; all outputs 0 during reset.
5. **Back-to-back:** 8 frames with zero idle, carrying 0xCAFEF00D then 0x12345678 → two `RxValid` pulses exactly 4 frames apart, with correct data each time.
6. **Loopback:** connect the existing UART transmitter's `Tx` to `Rx`, send 0xA5A5_5A5A → `RxData` = 0xA5A55A5A and `RxValid` pulses once.

Source files
------------

// File: rtl/uart_word_rx.sv
// 8N1 UART receiver that assembles DATA_BITS/8 consecutive bytes (LSB byte first)
// into one word, with a 2-flop input synchronizer, mid-bit sampling and framing checks.
module uart_word_rx #(
  parameter int DATA_BITS    = 32,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 Rx,
  output logic [DATA_BITS-1:0] RxData,
  output logic                 RxValid,
  output logic                 RxFrameErr,
  output logic                 RxBusy
);

  localparam int NB    = DATA_BITS / 8;
  localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;
  localparam int CNT_W = $clog2(CLKS_PER_BIT);

  // The IDLE->START edge already consumes one cycle of the half-bit wait.
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 2);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NB - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;

  state_t               state;
  logic                 rx_meta;
  logic                 rx_s;
  logic [CNT_W-1:0]     clk_cnt;
  logic [2:0]           bit_cnt;
  logic [7:0]           shreg;
  logic [IDX_W-1:0]     idx;
  logic [DATA_BITS-1:0] word_q;
  logic [DATA_BITS-1:0] word_ins;

  // Synchronizer resets high so a released reset never looks like a start bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= Rx;
      rx_s    <= rx_meta;
    end
  end

  always_comb begin
    word_ins = word_q;
    for (int b = 0; b < NB; b++) begin
      if (idx == IDX_W'(b)) word_ins[8*b +: 8] = shreg;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      clk_cnt    <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      idx        <= '0;
      word_q     <= '0;
      RxData     <= '0;
      RxValid    <= 1'b0;
      RxFrameErr <= 1'b0;
      RxBusy     <= 1'b0;
    end else begin
      RxValid    <= 1'b0;
      RxFrameErr <= 1'b0;
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state   <= START;
            clk_cnt <= '0;
            RxBusy  <= 1'b1;
          end
        end
        START: begin
          if (clk_cnt == HALF_LAST) begin
            if (!rx_s) begin
              state   <= DATA;
              bit_cnt <= '0;
              clk_cnt <= '0;
            end else begin
              state  <= IDLE;
              RxBusy <= 1'b0;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        DATA: begin
          if (clk_cnt == FULL_LAST) begin
            clk_cnt <= '0;
            shreg   <= {rx_s, shreg[7:1]};
            if (bit_cnt == 3'd7) state <= STOP;
            else                 bit_cnt <= bit_cnt + 1'b1;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        STOP: begin
          if (clk_cnt == FULL_LAST) begin
            clk_cnt <= '0;
            if (rx_s) begin
              word_q <= word_ins;
              if (idx == LAST_IDX) begin
                RxData  <= word_ins;
                RxValid <= 1'b1;
                idx     <= '0;
              end else begin
                idx <= idx + 1'b1;
              end
              state  <= IDLE;
              RxBusy <= 1'b0;
            end else begin
              // Bad stop bit: drop the byte and restart word assembly from byte 0.
              RxFrameErr <= 1'b1;
              idx        <= '0;
              state      <= BRK;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        BRK: begin
          if (rx_s) begin
            state  <= IDLE;
            RxBusy <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          RxBusy <= 1'b0;
        end
      endcase
    end
  end

endmodule
